count_disp_drv: RTL and testbench

- Downstream display stage for the 8-bit event/timer counter output.
- Converts the unsigned binary count to 3 BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes the result onto a 4-digit common-anode 7-segment display.
- Sits between the counter's `count` output and the board's anode/segment pins.

---
 rtl/count_disp_drv.sv | 177 +++++++++++++++++
 tb/tb_count_disp_drv.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/count_disp_drv.sv
`default_nettype none
// ============================================================================
// Module   : count_disp_drv
// Purpose  : Display driver for an 8-bit counter value. A sequential
//            shift-add-3 (double-dabble) engine converts the binary value to
//            three BCD digits, which are then time-multiplexed onto a 4-digit
//            common-anode 7-segment display.
// Ports    : clk   - system clock, all logic on posedge
//            rst   - synchronous active-high reset
//            value - unsigned binary value to display (0..255)
//            an    - anode enables, active low (an[0]=ones .. an[2]=hundreds,
//                    an[3] unused and always off)
//            seg   - segments {g,f,e,d,c,b,a}, active low
//            dp    - decimal point, active low, held off
//            bcd   - latched BCD result {hundreds,tens,ones}
//            busy  - high while a conversion is in progress
// Revision : 1.0 - initial release
// ============================================================================
module count_disp_drv #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] C_REFRESH_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [3:0] C_AN_OFF  = 4'b1111;
  localparam logic [6:0] C_SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADJ   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [19:0]   r_shift;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_last_val;
  logic [CW-1:0] r_refresh;
  logic [1:0]    r_scan;

  // Add 3 to a BCD nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Conversion engine. bcd is written only in DONE, so consumers never see
  // a partially converted result; a reset simply discards the shift register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= 20'd0;
      r_bit_cnt  <= 3'd0;
      r_last_val <= 8'd0;
      bcd        <= 12'h000;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (value != r_last_val) begin
            r_shift    <= {12'd0, value};
            r_last_val <= value;
            r_bit_cnt  <= 3'd0;
            busy       <= 1'b1;
            r_state    <= S_ADJ;
          end
        end
        S_ADJ: begin
          r_shift[19:16] <= add3(r_shift[19:16]);
          r_shift[15:12] <= add3(r_shift[15:12]);
          r_shift[11:8]  <= add3(r_shift[11:8]);
          r_state        <= S_SHIFT;
        end
        S_SHIFT: begin
          r_shift   <= r_shift << 1;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_state   <= (r_bit_cnt == 3'd7) ? S_DONE : S_ADJ;
        end
        S_DONE: begin
          bcd     <= r_shift[19:8];
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Refresh timer: each digit slot is held for REFRESH_DIV cycles.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_scan    <= 2'd0;
    end else if (r_refresh == C_REFRESH_LAST) begin
      r_refresh <= '0;
      r_scan    <= r_scan + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit multiplexer. Leading-zero blanking looks at the latched result so
  // the whole display moves together when bcd updates.
  // --------------------------------------------------------------------------
  logic w_hund_zero;
  logic w_blank_tens;
  logic w_blank_hund;

  assign w_hund_zero  = (bcd[11:8] == 4'd0);
  assign w_blank_hund = (BLANK_LZ != 0) && w_hund_zero;
  assign w_blank_tens = (BLANK_LZ != 0) && w_hund_zero && (bcd[7:4] == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= C_AN_OFF;
      seg <= C_SEG_OFF;
      dp  <= 1'b1;
    end else begin
      dp <= 1'b1;
      case (r_scan)
        2'd0: begin
          an  <= 4'b1110;
          seg <= decode(bcd[3:0]);
        end
        2'd1: begin
          an  <= w_blank_tens ? C_AN_OFF  : 4'b1101;
          seg <= w_blank_tens ? C_SEG_OFF : decode(bcd[7:4]);
        end
        2'd2: begin
          an  <= w_blank_hund ? C_AN_OFF  : 4'b1011;
          seg <= w_blank_hund ? C_SEG_OFF : decode(bcd[11:8]);
        end
        default: begin
          an  <= C_AN_OFF;
          seg <= C_SEG_OFF;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count_disp_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_disp_drv
// Purpose  : Self-checking bench for count_disp_drv. Two instances (leading
//            zero blanking on and off) share the stimulus; a decimal-level
//            reference model predicts bcd, busy and the scanned display.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_disp_drv;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  value = 8'd0;

  logic [3:0]  an_b, an_n;
  logic [6:0]  seg_b, seg_n;
  logic        dp_b, dp_n;
  logic [11:0] bcd_b, bcd_n;
  logic        busy_b, busy_n;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  count_disp_drv #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut_blank (
    .clk(clk), .rst(rst), .value(value),
    .an(an_b), .seg(seg_b), .dp(dp_b), .bcd(bcd_b), .busy(busy_b)
  );

  count_disp_drv #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) dut_noblank (
    .clk(clk), .rst(rst), .value(value),
    .an(an_n), .seg(seg_n), .dp(dp_n), .bcd(bcd_n), .busy(busy_n)
  );

  // ---------------- reference model (decimal level) ----------------
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         m_last, m_target, m_remain, m_dec, m_refresh, m_slot;
  logic       m_busy;
  logic [3:0] m_an_b, m_an_n;
  logic [6:0] m_seg_b, m_seg_n;

  task automatic model_reset();
    m_last = 0; m_target = 0; m_remain = 0; m_dec = 0;
    m_refresh = 0; m_slot = 0; m_busy = 1'b0;
    m_an_b = 4'hF; m_an_n = 4'hF; m_seg_b = 7'h7F; m_seg_n = 7'h7F;
  endtask

  // Display slot as it should appear for the given decimal value.
  task automatic slot_view(input int slot, input int dec, input bit blank_lz,
                           output logic [3:0] a, output logic [6:0] s);
    int o, t, h;
    o = dec % 10; t = (dec / 10) % 10; h = dec / 100;
    a = 4'hF; s = 7'h7F;
    if (slot == 0) begin
      a = 4'b1110; s = seg_tab[o];
    end else if (slot == 1 && !(blank_lz && h == 0 && t == 0)) begin
      a = 4'b1101; s = seg_tab[t];
    end else if (slot == 2 && !(blank_lz && h == 0)) begin
      a = 4'b1011; s = seg_tab[h];
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    slot_view(m_slot, m_dec, 1'b1, m_an_b, m_seg_b);
    slot_view(m_slot, m_dec, 1'b0, m_an_n, m_seg_n);
    if (m_refresh == DIV - 1) begin
      m_refresh = 0;
      m_slot = (m_slot + 1) % 4;
    end else begin
      m_refresh++;
    end
    // A conversion occupies 18 edges from the sampling edge to the result.
    if (m_remain == 0) begin
      if (int'(value) != m_last) begin
        m_last = int'(value); m_target = int'(value);
        m_remain = 17; m_busy = 1'b1;
      end
    end else begin
      m_remain--;
      if (m_remain == 0) begin
        m_dec = m_target; m_busy = 1'b0;
      end
    end
  endtask

  function automatic logic [11:0] to_bcd(input int d);
    return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("bcd_b",  16'(bcd_b),  16'(to_bcd(m_dec)));
    check("bcd_n",  16'(bcd_n),  16'(to_bcd(m_dec)));
    check("busy_b", 16'(busy_b), 16'(m_busy));
    check("busy_n", 16'(busy_n), 16'(m_busy));
    check("an_b",   16'(an_b),   16'(m_an_b));
    check("seg_b",  16'(seg_b),  16'(m_seg_b));
    check("an_n",   16'(an_n),   16'(m_an_n));
    check("seg_n",  16'(seg_n),  16'(m_seg_n));
    check("dp",     16'({dp_b, dp_n}), 16'(2'b11));
    check("digits_le9", 16'((bcd_b[11:8] <= 4'd9) && (bcd_b[7:4] <= 4'd9)
                            && (bcd_b[3:0] <= 4'd9)), 16'(1));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model says the conversion has finished (bounded).
  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    step();
    while ((m_busy || busy_b) && guard < 40) begin
      step();
      guard++;
    end
    check({tag, "_timeout"}, 16'(guard < 40), 16'(1));
  endtask

  initial begin
    model_reset();
    rst = 1'b1; value = 8'd0;
    steps(3);
    // reset state against fixed constants
    check("rst_an",   16'(an_b),   16'(4'b1111));
    check("rst_seg",  16'(seg_b),  16'(7'h7F));
    check("rst_bcd",  16'(bcd_b),  16'(12'h000));
    check("rst_busy", 16'(busy_b), 16'(0));
    rst = 1'b0;

    // value 0 held: no conversion, scan shows only the ones digit
    steps(20);
    check("zero_busy", 16'(busy_b), 16'(0));

    // 0 -> 255
    value = 8'd255;
    wait_idle("c255");
    check("bcd_255", 16'(bcd_b), 16'(12'h255));
    steps(16);

    // 7 with and without blanking
    value = 8'd7;
    wait_idle("c7");
    check("bcd_7", 16'(bcd_b), 16'(12'h007));
    steps(16);

    // 100 then 199 mid-conversion
    value = 8'd100;
    steps(5);
    value = 8'd199;
    steps(31);
    check("bcd_199", 16'(bcd_b), 16'(12'h199));
    check("busy_199", 16'(busy_b), 16'(0));

    // reset during SHIFT of a 200 conversion
    value = 8'd200;
    steps(2);
    rst = 1'b1;
    step();
    check("abort_busy", 16'(busy_b), 16'(0));
    check("abort_bcd",  16'(bcd_b),  16'(12'h000));
    check("abort_an",   16'(an_b),   16'(4'b1111));
    rst = 1'b0;
    steps(18);
    check("bcd_200", 16'(bcd_b), 16'(12'h200));

    // full sweep
    for (int v = 0; v < 256; v++) begin
      value = 8'(v);
      wait_idle("sweep");
    end

    // random values, hold times and occasional resets
    for (int k = 0; k < 80; k++) begin
      value = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 15) == 0);
      step();
      rst = 1'b0;
      steps($urandom_range(1, 25));
    end
    steps(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
